// File: rtl/easyaxi_rd_mst_if.sv
// Command, AXI AR/R and result signals of the EasyAXI read master.
// The master modport is the read master's view; slave is the environment's view.
interface easyaxi_rd_mst_if #(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 8,
  parameter int SIZE_W  = 3,
  parameter int BURST_W = 2,
  parameter int DATA_W  = 32,
  parameter int RESP_W  = 2
);
  logic               enable;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [ID_W-1:0]    cmd_id;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [LEN_W-1:0]   cmd_len;
  logic [SIZE_W-1:0]  cmd_size;
  logic [BURST_W-1:0] cmd_burst;

  logic               axi_mst_arvalid;
  logic               axi_mst_arready;
  logic [ID_W-1:0]    axi_mst_arid;
  logic [ADDR_W-1:0]  axi_mst_araddr;
  logic [LEN_W-1:0]   axi_mst_arlen;
  logic [SIZE_W-1:0]  axi_mst_arsize;
  logic [BURST_W-1:0] axi_mst_arburst;

  logic               axi_mst_rvalid;
  logic               axi_mst_rready;
  logic [DATA_W-1:0]  axi_mst_rdata;
  logic [RESP_W-1:0]  axi_mst_rresp;
  logic               axi_mst_rlast;

  logic               rd_data_valid;
  logic [DATA_W-1:0]  rd_data;
  logic [RESP_W-1:0]  rd_data_resp;
  logic               rd_data_last;

  logic               done_valid;
  logic [ID_W-1:0]    done_id;
  logic [RESP_W-1:0]  done_resp;
  logic [LEN_W:0]     done_beats;
  logic               done_len_err;

  modport master (
    input  enable, cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
    output cmd_ready,
    output axi_mst_arvalid, axi_mst_arid, axi_mst_araddr, axi_mst_arlen,
           axi_mst_arsize, axi_mst_arburst,
    input  axi_mst_arready,
    input  axi_mst_rvalid, axi_mst_rdata, axi_mst_rresp, axi_mst_rlast,
    output axi_mst_rready,
    output rd_data_valid, rd_data, rd_data_resp, rd_data_last,
    output done_valid, done_id, done_resp, done_beats, done_len_err
  );

  modport slave (
    output enable, cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
    input  cmd_ready,
    input  axi_mst_arvalid, axi_mst_arid, axi_mst_araddr, axi_mst_arlen,
           axi_mst_arsize, axi_mst_arburst,
    output axi_mst_arready,
    output axi_mst_rvalid, axi_mst_rdata, axi_mst_rresp, axi_mst_rlast,
    input  axi_mst_rready,
    input  rd_data_valid, rd_data, rd_data_resp, rd_data_last,
    input  done_valid, done_id, done_resp, done_beats, done_len_err
  );
endinterface

// File: rtl/easyaxi_rd_mst.sv
// Single-outstanding AXI read master: issues one AR per command, forwards each
// R beat on a registered port and reports worst response, beat count, length error.
module easyaxi_rd_mst #(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 8,
  parameter int SIZE_W  = 3,
  parameter int BURST_W = 2,
  parameter int DATA_W  = 32,
  parameter int RESP_W  = 2
) (
  input logic             clk,
  input logic             rst_n,
  easyaxi_rd_mst_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SIZE_W-1:0]  size_q, size_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               arvalid_q, arvalid_d;
  logic [LEN_W:0]     beat_cnt_q, beat_cnt_d;
  logic [RESP_W-1:0]  worst_q, worst_d;
  logic               len_err_q, len_err_d;

  logic               rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [RESP_W-1:0]  rd_resp_q, rd_resp_d;
  logic               rd_last_q, rd_last_d;
  logic               done_valid_q, done_valid_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [RESP_W-1:0]  done_resp_q, done_resp_d;
  logic [LEN_W:0]     done_beats_q, done_beats_d;
  logic               done_err_q, done_err_d;

  logic               cmd_fire, r_fire, last_idx;
  logic [LEN_W:0]     beat_inc;
  logic [RESP_W-1:0]  worst_nxt;
  logic               err_nxt;

  // cmd_ready is gated by rst_n so it reads 0 while reset is held.
  assign bus.cmd_ready      = rst_n & bus.enable & (state_q == IDLE);
  assign bus.axi_mst_rready = (state_q == DATA);
  assign cmd_fire           = bus.cmd_valid & bus.cmd_ready;
  assign r_fire             = bus.axi_mst_rvalid & (state_q == DATA);

  // The current beat is the final one the command asked for when its
  // pre-increment index equals len; any disagreement with rlast is a length error.
  assign last_idx  = (beat_cnt_q == {1'b0, len_q});
  assign beat_inc  = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;
  assign worst_nxt = (bus.axi_mst_rresp > worst_q) ? bus.axi_mst_rresp : worst_q;
  assign err_nxt   = len_err_q | (bus.axi_mst_rlast != last_idx);

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    arvalid_d    = arvalid_q;
    beat_cnt_d   = beat_cnt_q;
    worst_d      = worst_q;
    len_err_d    = len_err_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    rd_resp_d    = rd_resp_q;
    rd_last_d    = rd_last_q;
    done_valid_d = 1'b0;
    done_id_d    = done_id_q;
    done_resp_d  = done_resp_q;
    done_beats_d = done_beats_q;
    done_err_d   = done_err_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          id_d       = bus.cmd_id;
          addr_d     = bus.cmd_addr;
          len_d      = bus.cmd_len;
          size_d     = bus.cmd_size;
          burst_d    = bus.cmd_burst;
          beat_cnt_d = '0;
          worst_d    = '0;
          len_err_d  = 1'b0;
          arvalid_d  = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (arvalid_q && bus.axi_mst_arready) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (r_fire) begin
          rd_valid_d = 1'b1;
          rd_data_d  = bus.axi_mst_rdata;
          rd_resp_d  = bus.axi_mst_rresp;
          rd_last_d  = bus.axi_mst_rlast;
          beat_cnt_d = beat_inc;
          worst_d    = worst_nxt;
          len_err_d  = err_nxt;
          if (bus.axi_mst_rlast) begin
            done_valid_d = 1'b1;
            done_id_d    = id_q;
            done_resp_d  = worst_nxt;
            done_beats_d = beat_inc;
            done_err_d   = err_nxt;
            state_d      = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      arvalid_q    <= 1'b0;
      beat_cnt_q   <= '0;
      worst_q      <= '0;
      len_err_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_resp_q    <= '0;
      rd_last_q    <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_resp_q  <= '0;
      done_beats_q <= '0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      arvalid_q    <= arvalid_d;
      beat_cnt_q   <= beat_cnt_d;
      worst_q      <= worst_d;
      len_err_q    <= len_err_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_resp_q    <= rd_resp_d;
      rd_last_q    <= rd_last_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_resp_q  <= done_resp_d;
      done_beats_q <= done_beats_d;
      done_err_q   <= done_err_d;
    end
  end

  assign bus.axi_mst_arvalid = arvalid_q;
  assign bus.axi_mst_arid    = id_q;
  assign bus.axi_mst_araddr  = addr_q;
  assign bus.axi_mst_arlen   = len_q;
  assign bus.axi_mst_arsize  = size_q;
  assign bus.axi_mst_arburst = burst_q;
  assign bus.rd_data_valid   = rd_valid_q;
  assign bus.rd_data         = rd_data_q;
  assign bus.rd_data_resp    = rd_resp_q;
  assign bus.rd_data_last    = rd_last_q;
  assign bus.done_valid      = done_valid_q;
  assign bus.done_id         = done_id_q;
  assign bus.done_resp       = done_resp_q;
  assign bus.done_beats      = done_beats_q;
  assign bus.done_len_err    = done_err_q;

endmodule

// File: doc/easyaxi_rd_mst.md
Name: easyaxi_rd_mst

Overview:
- AXI read master that sits directly upstream of the AXI read slave.
- Accepts one read command at a time on a simple valid/ready command port and drives the AR channel.
- Collects every R beat, forwards each beat on a registered data port, and reports a completion record (worst response, beat count, length error).
- Single outstanding transaction. Used as the traffic initiator in the EasyAXI test system.

Parameters:
- ID_W, 4, AXI ID width
- ADDR_W, 32, AXI address width
- LEN_W, 8, AXI length width (beats = len+1)
- SIZE_W, 3, AXI size width
- BURST_W, 2, AXI burst width
- DATA_W, 32, AXI data width
- RESP_W, 2, AXI response width (OK=0, EXOKAY=1, SLVERR=2, DECERR=3)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  allow acceptance of new commands
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_id  in  ID_W  read ID
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  LEN_W  burst length minus one
- cmd_size  in  SIZE_W  beat size
- cmd_burst  in  BURST_W  burst type
- axi_mst_arvalid  out  1  AR valid
- axi_mst_arready  in  1  AR ready
- axi_mst_arid/araddr/arlen/arsize/arburst  out  ID_W/ADDR_W/LEN_W/SIZE_W/BURST_W  AR payload
- axi_mst_rvalid  in  1  R valid
- axi_mst_rready  out  1  R ready
- axi_mst_rdata  in  DATA_W  R data
- axi_mst_rresp  in  RESP_W  R response
- axi_mst_rlast  in  1  R last
- rd_data_valid  out  1  one-cycle pulse per received beat
- rd_data  out  DATA_W  received data
- rd_data_resp  out  RESP_W  response of that beat
- rd_data_last  out  1  beat carried rlast
- done_valid  out  1  one-cycle completion pulse
- done_id  out  ID_W  ID of completed command
- done_resp  out  RESP_W  worst response seen in the burst
- done_beats  out  LEN_W+1  beats received
- done_len_err  out  1  rlast position did not match len

Behaviour:
- Reset: reset is asynchronous, active-low on rst_n; the clock is clk. While reset is asserted, state=IDLE and every output is 0, including axi_mst_arvalid and the AR payload. This holds even mid-burst; no completion record is produced for the aborted burst.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - cmd_ready = enable & (state==IDLE).
  - On a command handshake, latch id/addr/len/size/burst, clear beat_cnt, worst_resp and len_err, then go to ADDR.
  - If enable is low, no command is accepted.
- ADDR:
  - axi_mst_arvalid=1 with the latched payload, registered, so arvalid rises the cycle after the command handshake.
  - Payload and arvalid stay stable until arready is seen.
  - On arvalid & arready, go to DATA. arvalid is 0 from the next cycle.
- DATA:
  - axi_mst_rready=1. It is 0 in all other states.
  - Each beat handshake:
    - rd_data_valid=1 on the next cycle, with rd_data, rd_data_resp, rd_data_last.
    - beat_cnt += 1.
    - worst_resp = max(worst_resp, rresp) by numeric code.
  - Early last: rlast=1 with beat_cnt != len → set len_err, go to DONE.
  - Missing last: beat with beat_cnt == len and rlast=0 → set len_err and keep accepting beats until rlast=1.
  - beat_cnt saturates at all-ones.
- DONE: for one cycle, done_valid=1 with done_id, done_resp, done_beats, done_len_err. Return to IDLE. cmd_ready is asserted again the cycle after DONE.
- enable deasserted mid-burst does not abort the burst; it only blocks the next command.
- R beats in IDLE or ADDR are not accepted (rready=0).
- done_* and rd_data_* hold their last values when their valid is low; only the valid is a pulse.
- Minimum command-to-command spacing: cmd handshake, then ADDR ≥1 cycle, then DATA ≥1 cycle, then DONE 1 cycle.

Test Plan:
- Single-beat read: cmd addr=0x0000, id=2, len=0, slave arready=1, one beat data=0x1 resp=OK rlast=1 → arvalid high exactly 1 cycle; rd_data_valid once with data 0x1; done_valid with done_resp=0, done_beats=1, done_len_err=0, done_id=2.
- Burst read: len=3, beats data 1,2,3,4 with rlast on 4th → 4 rd_data_valid pulses in order; done_beats=4; done_len_err=0.
- Error responses:
  - Beat responses OK, SLVERR, OK (len=2) → done_resp=2.
  - Decoder miss (addr=0x0040, len=3), 4 beats all DECERR → done_resp=3.
- Backpressure: arready held low 5 cycles after arvalid rises → arvalid and payload stable all 5 cycles; cmd_ready=0 throughout; handshake on cycle 6.
- Length error: len=3, rlast on beat 2 → done_beats=2, done_len_err=1.
  - len=1, rlast on beat 3 → done_beats=3, done_len_err=1.
- Enable and reset:
  - enable=0 with cmd_valid=1 → cmd_ready stays 0 and no arvalid.
  - rst_n pulsed low mid-burst after beat 2 of 4 → all outputs 0 immediately, no done_valid, next command accepted normally.
